// File: rtl/hc8_bus_pkg.sv
// ---------------------------------------------------------------------------
// hc8_bus_pkg
// Shared definitions for the HC8 external-bus target: FSM state encoding,
// I/O page register offsets and the default I/O page base address.
// ---------------------------------------------------------------------------
package hc8_bus_pkg;

  // Bus-cycle handshake states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Register offsets within the 4-entry I/O page.
  localparam logic [1:0] PORT_OUT = 2'd0;
  localparam logic [1:0] PORT_IN  = 2'd1;
  localparam logic [1:0] TICK     = 2'd2;
  localparam logic [1:0] STATUS   = 2'd3;

  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;

endpackage

// File: rtl/hc8_sync2.sv
// ---------------------------------------------------------------------------
// hc8_sync2
// Two-flop synchroniser for asynchronous input pins.
// Ports:
//   clk     in  system clock
//   nReset  in  asynchronous active-low reset (flops clear to 0)
//   d_i     in  asynchronous input vector
//   q_o     out synchronised vector (2 clk latency)
// ---------------------------------------------------------------------------
module hc8_sync2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, regardless of statement order.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hc8_bus_target.sv
// ---------------------------------------------------------------------------
// hc8_bus_target
// Responder on the HC8 external memory bus: byte RAM at 0x0000, a 4-register
// I/O page at IO_BASE (PORT_OUT, PORT_IN, TICK, STATUS) and programmable
// wait states signalled on nWAIT.
// Optional build macro: HC8_TGT_TICK_EN -- when defined the free-running
// TICK counter exists; otherwise IO_BASE+2 behaves as unmapped.
// Ports:
//   clk, nReset          clock / async active-low reset
//   addr[15:0]           CPU address
//   wdata[7:0]           CPU write data (latched at request edge)
//   rdata[7:0]           registered read data
//   nRAM_RD, nRAM_WR     active-low read / write strobes
//   nWAIT                low while the access is still in progress
//   port_in[7:0]         asynchronous input pins
//   port_out[7:0]        output port register
//   access_err           sticky error flag (STATUS[0])
// ---------------------------------------------------------------------------
module hc8_bus_target
  import hc8_bus_pkg::*;
#(
  parameter int unsigned RAM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] IO_BASE     = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  input  logic        nRAM_RD,
  input  logic        nRAM_WR,
  output logic        nWAIT,
  input  logic [7:0]  port_in,
  output logic [7:0]  port_out,
  output logic        access_err
);

  localparam int unsigned RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        write_q;

  logic [7:0]  rdata_q;
  logic [7:0]  port_out_q;
  logic        err_q;
  logic [7:0]  port_in_sync;
  logic [7:0]  mem [RAM_DEPTH];

  logic        req, both_low, both_high;
  logic        fire;
  logic [15:0] acc_addr;
  logic [7:0]  acc_wdata;
  logic        acc_write;

  logic [15:0]       io_off;
  logic              ram_hit, io_hit;
  logic [RAM_AW-1:0] ram_idx;
  logic [7:0]        rd_val;
  logic              mapped, port_we, ram_we, status_clr;
  logic              err_set, err_clr;

  assign req       = nRAM_RD ^ nRAM_WR;
  assign both_low  = ~nRAM_RD & ~nRAM_WR;
  assign both_high =  nRAM_RD &  nRAM_WR;

  hc8_sync2 #(.WIDTH(8)) u_sync_in (
    .clk    (clk),
    .nReset (nReset),
    .d_i    (port_in),
    .q_o    (port_in_sync)
  );

  // ---------------- FSM: state register (plus latched request) ------------
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      wcnt_q  <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (state_q == IDLE && req) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        write_q <= ~nRAM_WR;
      end
    end
  end

  // ---------------- FSM: next state ----------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = ACK;
          end else begin
            wcnt_d  = WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (both_high)           state_d = IDLE;  // CPU gave up: abort
        else if (wcnt_q == 4'd0) state_d = ACK;
        else                     wcnt_d  = wcnt_q - 4'd1;
      end
      ACK: begin
        // Waiting for strobe release keeps a held strobe from re-triggering.
        if (both_high) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs -------------------------------------------
  always_comb begin
    nWAIT = 1'b1;
    if ((state_q == WAIT) || (state_q == IDLE && req && WAIT_STATES != 0)) nWAIT = 1'b0;
    // A reset in the middle of an access must release the CPU immediately.
    if (!nReset) nWAIT = 1'b1;

    fire = ((state_q == IDLE) && req && (WAIT_STATES == 0)) ||
           ((state_q == WAIT) && !both_high && (wcnt_q == 4'd0));

    // With zero wait states the access happens on the request edge itself,
    // before the latches hold anything, so take the live bus values.
    if (state_q == IDLE) begin
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_write = ~nRAM_WR;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_write = write_q;
    end
  end

  // ---------------- Address decode and register file -----------------------
  assign io_off  = acc_addr - IO_BASE;
  assign ram_hit = 32'(acc_addr) < RAM_DEPTH;
  assign io_hit  = (acc_addr >= IO_BASE) && (io_off < 16'd4);
  assign ram_idx = acc_addr[RAM_AW-1:0];

`ifdef HC8_TGT_TICK_EN
  logic [7:0] tick_q;
  logic       tick_clr;
`endif

  always_comb begin
    rd_val     = 8'h00;
    mapped     = 1'b1;
    port_we    = 1'b0;
    ram_we     = 1'b0;
    status_clr = 1'b0;
`ifdef HC8_TGT_TICK_EN
    tick_clr   = 1'b0;
`endif
    if (ram_hit) begin
      rd_val = mem[ram_idx];
      ram_we = acc_write;
    end else if (io_hit) begin
      case (io_off[1:0])
        PORT_OUT: begin
          rd_val  = port_out_q;
          port_we = acc_write;
        end
        PORT_IN: begin
          rd_val = port_in_sync;
          if (acc_write) mapped = 1'b0;
        end
        TICK: begin
`ifdef HC8_TGT_TICK_EN
          rd_val   = tick_q;
          tick_clr = acc_write;
`else
          mapped   = 1'b0;
`endif
        end
        STATUS: begin
          rd_val     = {7'b0, err_q};
          status_clr = acc_write & acc_wdata[0];
        end
      endcase
    end else begin
      mapped = 1'b0;
    end
  end

  assign err_set = (fire & ~mapped) | ((state_q == IDLE) & both_low);
  assign err_clr = fire & status_clr;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rdata_q    <= 8'h00;
      port_out_q <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      if (fire && !acc_write) rdata_q    <= mapped ? rd_val : 8'h00;
      if (fire && port_we)    port_out_q <= acc_wdata;
      if (err_set)            err_q      <= 1'b1;
      else if (err_clr)       err_q      <= 1'b0;
    end
  end

  // NOTE: the RAM array has no reset; clearing it would turn the memory into
  // a bank of flops with a reset tree. Writes are gated by nReset so an
  // access in flight when reset arrives is dropped.
  always_ff @(posedge clk) begin
    if (fire && ram_we && nReset) mem[ram_idx] <= acc_wdata;
  end

`ifdef HC8_TGT_TICK_EN
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)              tick_q <= 8'h00;
    else if (fire && tick_clr) tick_q <= 8'h00;
    else                      tick_q <= tick_q + 8'd1;
  end
`endif

  assign rdata      = rdata_q;
  assign port_out   = port_out_q;
  assign access_err = err_q;

endmodule

// File: tb/tb_hc8_bus_target.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_hc8_bus_target
// Three targets with 0, 1 and 3 wait states share clock and reset. A
// transaction-level model (byte arrays, port/err/rdata variables, an edge
// counter for TICK) predicts visible state; a compare process checks
// rdata/port_out/access_err of every target each cycle, and the directed
// sequence pins literal values and nWAIT behaviour.
// ---------------------------------------------------------------------------
module tb_hc8_bus_target;
  import hc8_bus_pkg::*;

  localparam int N = 3;
  localparam logic [15:0] IOB = IO_BASE_DEFAULT;
  int ws [N] = '{0, 1, 3};

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic [15:0] addr     [N];
  logic [7:0]  wdata    [N];
  logic [7:0]  rdata    [N];
  logic        nrd      [N];
  logic        nwr      [N];
  logic        nwait    [N];
  logic [7:0]  port_out [N];
  logic        aerr     [N];
  logic [7:0]  port_in;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned WS = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    hc8_bus_target #(.RAM_DEPTH(256), .WAIT_STATES(WS), .IO_BASE(IOB)) u_dut (
      .clk        (clk),
      .nReset     (nReset),
      .addr       (addr[g]),
      .wdata      (wdata[g]),
      .rdata      (rdata[g]),
      .nRAM_RD    (nrd[g]),
      .nRAM_WR    (nwr[g]),
      .nWAIT      (nwait[g]),
      .port_in    (port_in),
      .port_out   (port_out[g]),
      .access_err (aerr[g])
    );
  end

  // ---------------- model state ----------------
  logic [7:0]  m_ram      [N][256];
  logic [7:0]  m_port_out [N];
  logic [7:0]  m_rdata    [N];
  logic        m_err      [N];
  int unsigned m_tick_base[N];
  int unsigned edges;
  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Clock edges seen since reset released; TICK must equal edges elapsed.
  always @(posedge clk or negedge nReset)
    if (!nReset) edges <= 0;
    else         edges <= edges + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_port_out[i]  = 8'h00;
      m_rdata[i]     = 8'h00;
      m_err[i]       = 1'b0;
      m_tick_base[i] = 0;
    end
  endtask

  // Apply one completed access to the model, called just after its access edge.
  task automatic model_apply(input int i, input bit we, input logic [15:0] a, input logic [7:0] d);
    if (a < 16'd256) begin
      if (we) m_ram[i][a[7:0]] = d;
      else    m_rdata[i] = m_ram[i][a[7:0]];
    end else if (a == IOB) begin
      if (we) m_port_out[i] = d;
      else    m_rdata[i] = m_port_out[i];
    end else if (a == IOB + 16'd1) begin
      if (we) m_err[i] = 1'b1;
      else    m_rdata[i] = port_in;
    end else if (a == IOB + 16'd2) begin
`ifdef HC8_TGT_TICK_EN
      if (we) m_tick_base[i] = edges;
      else    m_rdata[i] = 8'(edges - 1 - m_tick_base[i]);
`else
      m_err[i] = 1'b1;
      if (!we) m_rdata[i] = 8'h00;
`endif
    end else if (a == IOB + 16'd3) begin
      if (we) begin
        if (d[0]) m_err[i] = 1'b0;
      end else begin
        m_rdata[i] = {7'b0, m_err[i]};
      end
    end else begin
      m_err[i] = 1'b1;
      if (!we) m_rdata[i] = 8'h00;
    end
  endtask

  // Full handshake on target i; checks nWAIT timing and returns rdata.
  task automatic bus_access(input int i, input bit we, input logic [15:0] a,
                            input logic [7:0] d, output logic [7:0] rd);
    int post;
    @(posedge clk); #1;
    addr[i] = a; wdata[i] = d; nrd[i] = we; nwr[i] = ~we;
    #1;
    check($sformatf("nwait_pre[%0d]", i), nwait[i], (ws[i] == 0));
    @(posedge clk); #1;  // request edge E0 has been taken
    post = 0;
    while (nwait[i] == 1'b0 && post < 40) begin
      post++;
      @(posedge clk); #1;
    end
    check($sformatf("nwait_cycles[%0d]", i), post, ws[i]);
    model_apply(i, we, a, d);
    rd = rdata[i];
    nrd[i] = 1'b1; nwr[i] = 1'b1;
  endtask

  // Single compare process: visible registers vs model, every cycle.
  initial begin
    forever begin
      @(posedge clk); #3;
      if (cmp_en) begin
        for (int i = 0; i < N; i++) begin
          check($sformatf("cyc_rdata[%0d]", i),    rdata[i],    m_rdata[i]);
          check($sformatf("cyc_port_out[%0d]", i), port_out[i], m_port_out[i]);
          check($sformatf("cyc_err[%0d]", i),      aerr[i],     m_err[i]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    for (int i = 0; i < N; i++) begin
      addr[i] = 16'h0000; wdata[i] = 8'h00; nrd[i] = 1'b1; nwr[i] = 1'b1;
    end
    port_in = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_rdata[%0d]", i),    rdata[i],    8'h00);
      check($sformatf("rst_port_out[%0d]", i), port_out[i], 8'h00);
      check($sformatf("rst_err[%0d]", i),      aerr[i],     1'b0);
      check($sformatf("rst_nwait[%0d]", i),    nwait[i],    1'b1);
    end
    @(posedge clk); #1;
    nReset = 1'b1;
    cmp_en = 1'b1;

    // One wait state: RAM write then read-back.
    bus_access(1, 1'b1, 16'h0010, 8'hA5, rd);
    bus_access(1, 1'b0, 16'h0010, 8'h00, rd);
    check("ws1_ram_read", rd, 8'hA5);

    // Zero wait states: PORT_OUT write and read-back.
    bus_access(0, 1'b1, IOB, 8'h3C, rd);
    check("ws0_port_out", port_out[0], 8'h3C);
    bus_access(0, 1'b0, IOB, 8'h00, rd);
    check("ws0_port_readback", rd, 8'h3C);

    // Synchronised input, write to read-only PORT_IN, STATUS read and clear.
    port_in = 8'h5A;
    repeat (3) @(posedge clk);
    bus_access(0, 1'b0, IOB + 16'd1, 8'h00, rd);
    check("port_in_read", rd, 8'h5A);
    bus_access(0, 1'b1, IOB + 16'd1, 8'h99, rd);
    check("port_in_wr_err", aerr[0], 1'b1);
    check("port_in_wr_port_out", port_out[0], 8'h3C);
    bus_access(0, 1'b0, IOB + 16'd3, 8'h00, rd);
    check("status_read", rd, 8'h01);
    bus_access(0, 1'b1, IOB + 16'd3, 8'h01, rd);
    check("status_clear0", aerr[0], 1'b0);

    // Unmapped read, then STATUS clear.
    bus_access(1, 1'b0, 16'h8000, 8'h00, rd);
    check("unmapped_rdata", rd, 8'h00);
    check("unmapped_err", aerr[1], 1'b1);
    bus_access(1, 1'b1, IOB + 16'd3, 8'h01, rd);
    check("status_clear1", aerr[1], 1'b0);

    // Three wait states: aborted write must leave RAM untouched.
    bus_access(2, 1'b1, 16'h0020, 8'h11, rd);
    @(posedge clk); #1;
    addr[2] = 16'h0020; wdata[2] = 8'hFF; nwr[2] = 1'b0;
    @(posedge clk); #1;
    check("abort_nwait_hold", nwait[2], 1'b0);
    nwr[2] = 1'b1;
    @(posedge clk); #1;
    check("abort_nwait_idle", nwait[2], 1'b1);
    bus_access(2, 1'b0, 16'h0020, 8'h00, rd);
    check("abort_old_value", rd, 8'h11);

`ifdef HC8_TGT_TICK_EN
    // TICK: clear, immediate read, then a read after wrapping.
    bus_access(0, 1'b1, IOB + 16'd2, 8'h00, rd);
    bus_access(0, 1'b0, IOB + 16'd2, 8'h00, rd);
    check("tick_after_clear", rd, 8'h01);
    bus_access(0, 1'b1, IOB + 16'd2, 8'h00, rd);
    repeat (300) @(posedge clk);
    bus_access(0, 1'b0, IOB + 16'd2, 8'h00, rd);
    check("tick_wrap", rd, 8'h2D);
`else
    bus_access(0, 1'b0, IOB + 16'd2, 8'h00, rd);
    check("tick_absent_rdata", rd, 8'h00);
    check("tick_absent_err", aerr[0], 1'b1);
    bus_access(0, 1'b1, IOB + 16'd3, 8'h01, rd);
`endif

    // Both strobes low: error, no access, FSM stays idle.
    @(posedge clk); #1;
    addr[1] = 16'h0010; wdata[1] = 8'h00; nrd[1] = 1'b0; nwr[1] = 1'b0;
    #1;
    check("both_low_nwait", nwait[1], 1'b1);
    @(posedge clk); #1;
    m_err[1] = 1'b1;
    check("both_low_err", aerr[1], 1'b1);
    nrd[1] = 1'b1; nwr[1] = 1'b1;
    bus_access(1, 1'b0, 16'h0010, 8'h00, rd);
    check("both_low_no_write", rd, 8'hA5);

    // Reset in the middle of a waited PORT_OUT write.
    bus_access(2, 1'b1, IOB, 8'h22, rd);
    @(posedge clk); #1;
    addr[2] = IOB; wdata[2] = 8'h77; nwr[2] = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_nwait_before", nwait[2], 1'b0);
    nReset = 1'b0;
    model_reset();
    #1;
    check("rst_mid_nwait", nwait[2], 1'b1);
    check("rst_mid_port_out", port_out[2], 8'h00);
    check("rst_mid_err", aerr[1], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    nwr[2] = 1'b1;
    @(posedge clk); #1;
    nReset = 1'b1;
    bus_access(2, 1'b0, IOB, 8'h00, rd);
    check("rst_write_dropped", rd, 8'h00);
`ifdef HC8_TGT_TICK_EN
    bus_access(0, 1'b0, IOB + 16'd2, 8'h00, rd);
    check("tick_after_reset", rd, 8'h06);
`endif

    repeat (2) @(posedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
